// File: rtl/sequenciador_entrada_pkg.sv
// Shared definitions for the ALU-board entry sequencer and its display decoder.
// Holds the state/etapa encoding and the widths of the stage code and latency counter.
package sequenciador_entrada_pkg;

   localparam int unsigned ETAPA_W = 3;
   localparam int unsigned CONT_W  = 4;

   // Stage codes double as the etapa value shown on the LEDs / 7-segment display.
   typedef enum logic [ETAPA_W-1:0] {
      ESPERA_A  = 3'd0,
      ESPERA_B  = 3'd1,
      ESPERA_OP = 3'd2,
      EXECUTA   = 3'd3,
      MOSTRA    = 3'd4
   } estado_t;

endpackage

// File: rtl/sequenciador_entrada_if.sv
// Handshake bundle between the button debouncers, the sequencer and the board registers.
// Signals: pulso_confirma / pulso_cancela (debounced one-cycle pulses),
//          hab_a / hab_b / hab_op / hab_res (register load enables),
//          resultado_valido (result on display), etapa (current stage code).
// master: debouncer/board side; slave: the sequencer.
interface sequenciador_entrada_if;
   import sequenciador_entrada_pkg::*;

   logic               pulso_confirma;
   logic               pulso_cancela;
   logic               hab_a;
   logic               hab_b;
   logic               hab_op;
   logic               hab_res;
   logic               resultado_valido;
   logic [ETAPA_W-1:0] etapa;

   modport master (
      output pulso_confirma, pulso_cancela,
      input  hab_a, hab_b, hab_op, hab_res, resultado_valido, etapa
   );

   modport slave (
      input  pulso_confirma, pulso_cancela,
      output hab_a, hab_b, hab_op, hab_res, resultado_valido, etapa
   );

endinterface

// File: rtl/sequenciador_entrada_contador_latencia.sv
// ALU settling-latency down-counter.
// Ports: clk, rst (async, active-high), carrega (load LATENCIA),
//        decrementa (count down one step), zero (count is 0).
// Saturates at 0; never wraps.
module contador_latencia
   import sequenciador_entrada_pkg::*;
#(
   parameter int unsigned LATENCIA = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic carrega,
   input  logic decrementa,
   output logic zero
);

   logic [CONT_W-1:0] contagem;

   // Load has priority over decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contagem <= '0;
      end else if (carrega) begin
         contagem <= CONT_W'(LATENCIA);
      end else if (decrementa && (contagem != '0)) begin
         contagem <= contagem - CONT_W'(1);
      end
   end

   assign zero = (contagem == '0);

endmodule

// File: rtl/sequenciador_entrada.sv
// Entry sequencer for the 8-bit ALU board: walks operand A, operand B and opcode
// entry on confirm pulses, waits LATENCIA cycles, captures the result and shows it.
// Ports: clk, rst (async, active-high), ctrl (sequenciador_entrada_if.slave).
// All outputs come straight from flops.
module sequenciador_entrada
   import sequenciador_entrada_pkg::*;
#(
   parameter int unsigned LATENCIA = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sequenciador_entrada_if.slave ctrl
);

   estado_t estado;
   logic    hab_a;
   logic    hab_b;
   logic    hab_op;
   logic    hab_res;
   logic    valido;
   logic    carrega_c;
   logic    decrementa_c;
   logic    zero;

   // Counter is armed on the accepted opcode confirm and runs only while executing.
   assign carrega_c    = (estado == ESPERA_OP) && ctrl.pulso_confirma && !ctrl.pulso_cancela;
   assign decrementa_c = (estado == EXECUTA);

   contador_latencia #(
      .LATENCIA   (LATENCIA)
   ) u_contador (
      .clk        (clk),
      .rst        (rst),
      .carrega    (carrega_c),
      .decrementa (decrementa_c),
      .zero       (zero)
   );

   // Sequencer state and registered enables; cancel overrides everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado  <= ESPERA_A;
         hab_a   <= 1'b0;
         hab_b   <= 1'b0;
         hab_op  <= 1'b0;
         hab_res <= 1'b0;
         valido  <= 1'b0;
      end else begin
         hab_a   <= 1'b0;
         hab_b   <= 1'b0;
         hab_op  <= 1'b0;
         hab_res <= 1'b0;
         valido  <= 1'b0;
         if (ctrl.pulso_cancela) begin
            estado <= ESPERA_A;
         end else begin
            case (estado)
               ESPERA_A: begin
                  if (ctrl.pulso_confirma) begin
                     hab_a  <= 1'b1;
                     estado <= ESPERA_B;
                  end
               end
               ESPERA_B: begin
                  if (ctrl.pulso_confirma) begin
                     hab_b  <= 1'b1;
                     estado <= ESPERA_OP;
                  end
               end
               ESPERA_OP: begin
                  if (ctrl.pulso_confirma) begin
                     hab_op <= 1'b1;
                     estado <= EXECUTA;
                  end
               end
               EXECUTA: begin
                  if (zero) begin
                     hab_res <= 1'b1;
                     estado  <= MOSTRA;
                  end
               end
               MOSTRA: begin
                  // A confirm here is already the next operand A.
                  if (ctrl.pulso_confirma) begin
                     hab_a  <= 1'b1;
                     estado <= ESPERA_B;
                  end else begin
                     valido <= 1'b1;
                  end
               end
               default: estado <= ESPERA_A;
            endcase
         end
      end
   end

   assign ctrl.hab_a            = hab_a;
   assign ctrl.hab_b            = hab_b;
   assign ctrl.hab_op           = hab_op;
   assign ctrl.hab_res          = hab_res;
   assign ctrl.resultado_valido = valido;
   assign ctrl.etapa            = estado;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Bench for sequenciador_entrada: one instance with LATENCIA=2, one with LATENCIA=0.
// Expected outputs per cycle are pushed to a scoreboard when stimulus is driven
// and popped/compared #1 after the sampling edge.
module tb_sequenciador_entrada;

   typedef struct {
      bit         conf;
      bit         canc;
      logic [7:0] exp;   // {hab_a, hab_b, hab_op, hab_res, resultado_valido, etapa[2:0]}
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   vec_t tab[$];
   vec_t sb[$];

   sequenciador_entrada_if if2 ();
   sequenciador_entrada_if if0 ();

   sequenciador_entrada #(.LATENCIA(2)) dut2 (.clk(clk), .rst(rst), .ctrl(if2));
   sequenciador_entrada #(.LATENCIA(0)) dut0 (.clk(clk), .rst(rst), .ctrl(if0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input bit conf, input bit canc, input bit a, input bit b,
                               input bit op, input bit res, input bit v, input int et);
      vec_t r;
      r.conf = conf;
      r.canc = canc;
      r.exp  = {a, b, op, res, v, 3'(et)};
      return r;
   endfunction

   function automatic logic [7:0] obs(input bit sel0);
      if (sel0)
         return {if0.hab_a, if0.hab_b, if0.hab_op, if0.hab_res, if0.resultado_valido, if0.etapa};
      return {if2.hab_a, if2.hab_b, if2.hab_op, if2.hab_res, if2.resultado_valido, if2.etapa};
   endfunction

   task automatic check(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s[%0d]: got={a,b,op,res,v,etapa}=%b want=%b", nm, idx, got, want);
      end
   endtask

   // Drive one cycle of stimulus on the selected instance, score it after the edge.
   task automatic step(input bit sel0, input vec_t v, input string nm, input int idx);
      vec_t e;
      @(negedge clk);
      if2.pulso_confirma = 1'b0;
      if2.pulso_cancela  = 1'b0;
      if0.pulso_confirma = 1'b0;
      if0.pulso_cancela  = 1'b0;
      if (sel0) begin
         if0.pulso_confirma = v.conf;
         if0.pulso_cancela  = v.canc;
      end else begin
         if2.pulso_confirma = v.conf;
         if2.pulso_cancela  = v.canc;
      end
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(nm, idx, obs(sel0), e.exp);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      if2.pulso_confirma = 1'b0;
      if2.pulso_cancela  = 1'b0;
      if0.pulso_confirma = 1'b0;
      if0.pulso_cancela  = 1'b0;

      // LATENCIA=2 vectors: conf, canc, a, b, op, res, v, etapa
      tab.push_back(mk(1,0, 1,0,0,0,0, 1));
      for (int i = 0; i < 9; i++) tab.push_back(mk(0,0, 0,0,0,0,0, 1));
      tab.push_back(mk(1,0, 0,1,0,0,0, 2));
      for (int i = 0; i < 9; i++) tab.push_back(mk(0,0, 0,0,0,0,0, 2));
      tab.push_back(mk(1,0, 0,0,1,0,0, 3));
      tab.push_back(mk(0,0, 0,0,0,0,0, 3));
      tab.push_back(mk(0,0, 0,0,0,0,0, 3));
      tab.push_back(mk(0,0, 0,0,0,1,0, 4));     // hab_res 3 cycles after hab_op
      for (int i = 0; i < 7; i++) tab.push_back(mk(0,0, 0,0,0,0,1, 4));
      tab.push_back(mk(1,0, 1,0,0,0,0, 1));     // confirm in MOSTRA -> new operand A
      tab.push_back(mk(1,0, 0,1,0,0,0, 2));
      tab.push_back(mk(1,0, 0,0,1,0,0, 3));
      tab.push_back(mk(0,0, 0,0,0,0,0, 3));
      tab.push_back(mk(0,1, 0,0,0,0,0, 0));     // cancel one cycle before hab_res
      for (int i = 0; i < 4; i++) tab.push_back(mk(0,0, 0,0,0,0,0, 0));
      tab.push_back(mk(1,0, 1,0,0,0,0, 1));
      tab.push_back(mk(1,1, 0,0,0,0,0, 0));     // confirm+cancel in ESPERA_B
      tab.push_back(mk(0,0, 0,0,0,0,0, 0));
      tab.push_back(mk(1,0, 1,0,0,0,0, 1));
      tab.push_back(mk(1,0, 0,1,0,0,0, 2));
      tab.push_back(mk(1,0, 0,0,1,0,0, 3));
      tab.push_back(mk(1,0, 0,0,0,0,0, 3));     // confirms ignored in EXECUTA
      tab.push_back(mk(1,0, 0,0,0,0,0, 3));
      tab.push_back(mk(1,0, 0,0,0,1,0, 4));
      tab.push_back(mk(0,0, 0,0,0,0,1, 4));
      tab.push_back(mk(0,1, 0,0,0,0,0, 0));     // cancel in MOSTRA drops valid
      tab.push_back(mk(0,0, 0,0,0,0,0, 0));

      // Reset state on both instances while reset is held.
      #2;
      check("reset_l2", 0, obs(1'b0), 8'h00);
      check("reset_l0", 0, obs(1'b1), 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tab.size(); i++) step(1'b0, tab[i], "lat2", i);

      // LATENCIA=0: hab_res directly follows hab_op.
      step(1'b1, mk(1,0, 1,0,0,0,0, 1), "lat0", 0);
      step(1'b1, mk(1,0, 0,1,0,0,0, 2), "lat0", 1);
      step(1'b1, mk(1,0, 0,0,1,0,0, 3), "lat0", 2);
      step(1'b1, mk(0,0, 0,0,0,1,0, 4), "lat0", 3);
      step(1'b1, mk(0,0, 0,0,0,0,1, 4), "lat0", 4);
      step(1'b1, mk(1,0, 1,0,0,0,0, 1), "lat0", 5);
      step(1'b1, mk(1,0, 0,1,0,0,0, 2), "lat0", 6);
      step(1'b1, mk(1,0, 0,0,1,0,0, 3), "lat0", 7);
      step(1'b1, mk(1,0, 0,0,0,1,0, 4), "lat0", 8);   // confirm in EXECUTA ignored
      step(1'b1, mk(0,0, 0,0,0,0,1, 4), "lat0", 9);

      // Async reset mid-EXECUTA on the LATENCIA=2 instance.
      step(1'b0, mk(1,0, 1,0,0,0,0, 1), "arst", 0);
      step(1'b0, mk(1,0, 0,1,0,0,0, 2), "arst", 1);
      step(1'b0, mk(1,0, 0,0,1,0,0, 3), "arst", 2);
      if2.pulso_confirma = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_async", 0, obs(1'b0), 8'h00);
      @(posedge clk);
      #1;
      check("arst_hold", 0, obs(1'b0), 8'h00);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, mk(1,0, 1,0,0,0,0, 1), "arst", 3);
      step(1'b0, mk(0,0, 0,0,0,0,0, 1), "arst", 4);

      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard: leftover=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sequenciador_entrada.md
# sequenciador_entrada

Control FSM sitting directly downstream of the button debouncers of the 8-bit ALU board. It consumes the single-cycle pulses from the `confirma` and `cancela` debouncers and sequences operand A, operand B and opcode entry from the switches by driving the load-enable (`habilita`) inputs of the operand, opcode, result and flag registers. After the opcode is loaded it waits a fixed ALU settling latency, captures the result and holds a valid indication for the display until the next entry starts.

## Interface
Parameters:
- `LATENCIA`, default 2: cycles waited between opcode load and result capture; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pulso_confirma`  in  1  one-cycle pulse from the confirm-button debouncer.
- `pulso_cancela`  in  1  one-cycle pulse from the cancel-button debouncer.
- `hab_a`  out  1  load enable, operand A 8-bit register.
- `hab_b`  out  1  load enable, operand B 8-bit register.
- `hab_op`  out  1  load enable, 3-bit opcode register.
- `hab_res`  out  1  load enable, 16-bit result register and 1-bit flag registers.
- `resultado_valido`  out  1  high while a captured result is on display.
- `etapa`  out  3  current state code, for LEDs/7-segment.

## Operation
- States and `etapa` codes: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EXECUTA=3, MOSTRA=4. Codes 5..7 are unreachable and recover to ESPERA_A on the next edge.
- ESPERA_A + confirm: pulse `hab_a`, then go to ESPERA_B.
- ESPERA_B + confirm: pulse `hab_b`, then go to ESPERA_OP.
- ESPERA_OP + confirm: pulse `hab_op`, load the latency counter with `LATENCIA`, then go to EXECUTA.
- EXECUTA: the counter decrements once per cycle. When it reaches 0, pulse `hab_res` and go to MOSTRA. Confirm pulses are ignored in this state.
- MOSTRA: `resultado_valido`=1. Confirm pulses `hab_a` and goes to ESPERA_B, so the new operand A starts the next entry directly.
- Cancel in any state: go to ESPERA_A with no enable pulse. Any pending `hab_res` is suppressed. Operand registers are not cleared.
- Cancel and confirm in the same cycle: cancel wins.
- At most one `hab_*` output is high in any cycle. Each is high for exactly one cycle per accepted event.
- Latency counter is 4 bits, counts down only, and does not wrap.

## Timing
- Reset values: state ESPERA_A, counter 0. All `hab_*`=0, `resultado_valido`=0, `etapa`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Confirm sampled at edge k means the matching `hab_*` is high during cycle k..k+1, so the target register loads at edge k+1.
- `etapa` updates at the same edge that raises the `hab_*`.
- Opcode confirm at edge k:
  - `hab_op` is high in the cycle after edge k.
  - `hab_res` is high in the cycle after edge k+1+LATENCIA.
  - `resultado_valido` rises at edge k+2+LATENCIA.
  - With LATENCIA=0, `hab_res` follows `hab_op` back-to-back.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). After reset is released, the first confirm pulse is treated as operand A.
- Input pulses are assumed to be exactly one cycle. A level held high would be accepted once per cycle, which is the debouncer's responsibility to prevent.

## Structure
- Shared package: state encoding constants (ESPERA_A..MOSTRA) and the 3-bit `etapa` width. The display decoder uses the same package.
- One sub-module, `contador_latencia`: 4-bit down-counter with asynchronous `rst`, a `carrega` input (load `LATENCIA`) and a `zero` output.
- The FSM and the output registers stay in the top module.

## Test plan
- Reset, then three confirm pulses 10 cycles apart with LATENCIA=2:
  - `hab_a`, `hab_b`, `hab_op` each pulse once, one cycle after their confirm.
  - `hab_res` pulses 3 cycles after `hab_op`.
  - `etapa` sequence is 0→1→2→3→4; `resultado_valido`=1 from then on.
- In MOSTRA, send a confirm: `hab_a` pulses, `etapa`=1, `resultado_valido` drops to 0 in the same cycle.
- Cancel pulse during EXECUTA, one cycle before `hab_res` would fire: no `hab_res`, `etapa`=0, `resultado_valido` stays 0.
- Confirm and cancel in the same cycle while in ESPERA_B: no `hab_b`, `etapa`=0.
- Confirm pulses during EXECUTA: ignored, and `hab_res` timing is unchanged. Repeat with LATENCIA=0: `hab_res` immediately follows `hab_op`.
- Assert `rst` asynchronously mid-EXECUTA:
  - All outputs go to 0 before the next clock edge.
  - After release, the first confirm produces `hab_a`.
